// File: rtl/out_uart_tx.sv
// Output-port drain stage: buffers CPU output words in a FIFO and streams them
// as 8N1 UART bytes, most-significant byte first.
module out_uart_tx #(
    parameter int unsigned WIDTH        = 24,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       outFlag,
    input  logic [WIDTH-1:0]           out,
    output logic                       tx,
    output logic                       busy,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] fifoCount
);

    localparam int unsigned CW     = $clog2(DEPTH + 1);
    localparam int unsigned PW     = $clog2(DEPTH);
    localparam int unsigned NBYTES = WIDTH / 8;
    localparam int unsigned BYW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned TW     = $clog2(CLKS_PER_BIT);

    localparam logic [TW-1:0]  TIMER_RELOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [BYW-1:0] LAST_BYTE    = BYW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] shreg;
    logic [BYW-1:0]   byte_idx;
    logic [2:0]       bit_idx;
    logic [TW-1:0]    timer;
    logic             full;
    logic             pop;
    logic             push;
    logic [7:0]       cur_byte;

    assign full     = (fifoCount == CW'(DEPTH));
    assign pop      = (state == IDLE) && (fifoCount != '0);
    // A full FIFO still accepts a word on the edge that pops its head.
    assign push     = outFlag && (!full || pop);
    assign busy     = (state != IDLE) || (fifoCount != '0);
    // The outgoing byte is always the top byte; the word shifts left between bytes.
    assign cur_byte = shreg[WIDTH-1 -: 8];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifoCount <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                fifoCount <= fifoCount + 1'b1;
            end else if (pop && !push) begin
                fifoCount <= fifoCount - 1'b1;
            end
            if (outFlag && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= out;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            shreg    <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            timer    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shreg    <= mem[rd_ptr];
                        byte_idx <= LAST_BYTE;
                        timer    <= TIMER_RELOAD;
                        tx       <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (timer == '0) begin
                        timer   <= TIMER_RELOAD;
                        bit_idx <= '0;
                        tx      <= cur_byte[0];
                        state   <= DATA;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                DATA: begin
                    if (timer == '0) begin
                        timer <= TIMER_RELOAD;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                STOP: begin
                    if (timer == '0) begin
                        timer <= TIMER_RELOAD;
                        if (byte_idx != '0) begin
                            byte_idx <= byte_idx - 1'b1;
                            shreg    <= shreg << 8;
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: directed pushes feed a scoreboard; a UART receiver
// monitor decodes the tx line and checks words, stop bits and frame gaps.
module tb_out_uart_tx;

    typedef struct {
        logic [23:0] w;
        int          gap;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        outFlag;
    logic [23:0] out;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [2:0]  fifoCount;

    int   n_checks;
    int   n_fail;
    exp_t sb [$];

    // Receiver monitor state
    bit          rx_active;
    int          cnt;
    int          gap;
    int          word_gap;
    int          byte_n;
    int          rx_starts;
    logic [7:0]  rbyte;
    logic [23:0] acc;
    exp_t        e;

    out_uart_tx #(
        .WIDTH       (24),
        .DEPTH       (4),
        .CLKS_PER_BIT(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .outFlag  (outFlag),
        .out      (out),
        .tx       (tx),
        .busy     (busy),
        .overflow (overflow),
        .fifoCount(fifoCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_push(input logic [23:0] w, input int g);
        exp_t x;
        x.w   = w;
        x.gap = g;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || rx_active || byte_n != 0 || busy) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(n < budget), 32'd1);
        repeat (3) @(negedge clock);
    endtask

    // UART receiver sampling at mid-bit on falling edges (4 clocks per bit)
    always @(negedge clock) begin
        if (reset) begin
            rx_active = 1'b0;
            byte_n    = 0;
            gap       = 0;
            cnt       = 0;
        end else if (!rx_active) begin
            if (tx == 1'b0) begin
                rx_active = 1'b1;
                cnt       = 0;
                rx_starts++;
                if (byte_n > 0) check("byte_gap", gap, 1);
                else word_gap = gap;
            end else begin
                gap++;
            end
        end else begin
            cnt++;
            if (cnt == 2) begin
                check("rx_start", 32'(tx), 32'd0);
            end else if (cnt >= 6 && cnt <= 34 && (cnt % 4) == 2) begin
                rbyte[(cnt - 6) / 4] = tx;
            end else if (cnt == 38) begin
                check("rx_stop", 32'(tx), 32'd1);
                acc       = {acc[15:0], rbyte};
                byte_n++;
                rx_active = 1'b0;
                gap       = 0;
                if (byte_n == 3) begin
                    byte_n = 0;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rx_word: got %06h expected no word", acc);
                    end else begin
                        e = sb.pop_front();
                        check("rx_word", 32'(acc), 32'(e.w));
                        if (e.gap >= 0) check("word_gap", word_gap, e.gap);
                    end
                end
            end
        end
    end

    logic [23:0] full_words [6];
    logic [23:0] wrap_words [10];
    int          starts0;
    int          max_count;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rx_starts = 0;
        acc       = '0;
        rbyte     = '0;
        word_gap  = 0;
        full_words = '{24'hC0FFEE, 24'h0BADF0, 24'h123ABC, 24'hFEDCBA, 24'h55AA55, 24'h0F0F0F};
        wrap_words = '{24'h123456, 24'h789ABC, 24'hDEF012, 24'h345678, 24'h9ABCDE,
                       24'hF00F55, 24'hAA55AA, 24'h00FF00, 24'h800001, 24'h7E7E81};
        reset   = 1'b1;
        outFlag = 1'b0;
        out     = '0;

        // Reset state
        #12;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifoCount), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Single word: start bit one clock after push, frame 120 clocks
        @(negedge clock);
        outFlag = 1'b1;
        out     = 24'hA53C01;
        sb_push(24'hA53C01, -1);
        @(posedge clock);
        #1;
        check("push_count", 32'(fifoCount), 32'd1);
        check("push_tx_idle", 32'(tx), 32'd1);
        @(negedge clock);
        outFlag = 1'b0;
        @(posedge clock);
        #1;
        check("pop_tx_start", 32'(tx), 32'd0);
        check("pop_count", 32'(fifoCount), 32'd0);
        check("pop_busy", 32'(busy), 32'd1);
        repeat (119) @(posedge clock);
        #1;
        check("frame_busy_end", 32'(busy), 32'd1);
        @(posedge clock);
        #1;
        check("frame_idle", 32'(busy), 32'd0);
        wait_drain("drain_single", 400);

        // Reset mid-frame during DATA bit 3 of the first byte
        @(negedge clock);
        outFlag = 1'b1;
        out     = 24'hA53C01;
        @(negedge clock);
        outFlag = 1'b0;
        repeat (17) @(posedge clock);
        #2;
        check("mid_bit3", 32'(tx), 32'd0);
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("async_tx", 32'(tx), 32'd1);
        check("async_busy", 32'(busy), 32'd0);
        check("async_count", 32'(fifoCount), 32'd0);
        check("async_ovf", 32'(overflow), 32'd0);
        repeat (3) @(negedge clock);
        reset   = 1'b0;
        starts0 = rx_starts;
        repeat (200) @(negedge clock);
        check("post_rst_quiet", rx_starts, starts0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Overflow: six back-to-back pushes, sixth dropped
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            outFlag = 1'b1;
            out     = 24'(i);
            if (i <= 5) sb_push(24'(i), (i == 1) ? -1 : 2);
            @(posedge clock);
            #1;
            if (i == 2) check("ovf_count2", 32'(fifoCount), 32'd1);
            if (i == 5) begin
                check("ovf_count5", 32'(fifoCount), 32'd4);
                check("ovf_before", 32'(overflow), 32'd0);
            end
            if (i == 6) begin
                check("ovf_count6", 32'(fifoCount), 32'd4);
                check("ovf_set", 32'(overflow), 32'd1);
            end
        end
        @(negedge clock);
        outFlag = 1'b0;
        wait_drain("drain_ovf", 2000);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO with a push on the edge that pops
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            outFlag = 1'b1;
            out     = full_words[i];
            sb_push(full_words[i], (i == 0) ? -1 : 2);
            @(posedge clock);
            #1;
        end
        check("full_count", 32'(fifoCount), 32'd4);
        @(negedge clock);
        outFlag = 1'b0;
        repeat (117) @(posedge clock);
        #1;
        check("full_pre_pop", 32'(fifoCount), 32'd4);
        @(negedge clock);
        outFlag = 1'b1;
        out     = full_words[5];
        sb_push(full_words[5], 2);
        @(posedge clock);
        #1;
        check("full_pop_count", 32'(fifoCount), 32'd4);
        check("full_pop_ovf", 32'(overflow), 32'd0);
        check("full_pop_tx", 32'(tx), 32'd0);
        @(negedge clock);
        outFlag = 1'b0;
        wait_drain("drain_full", 2000);

        // Pointer wrap: ten spaced words
        max_count = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            outFlag = 1'b1;
            out     = wrap_words[i];
            sb_push(wrap_words[i], -1);
            for (int c = 0; c < 130; c++) begin
                @(negedge clock);
                outFlag = 1'b0;
                if (int'(fifoCount) > max_count) max_count = int'(fifoCount);
            end
        end
        wait_drain("drain_wrap", 500);
        check("wrap_max_count", max_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
